// File: rtl/fifo_tx_serializer.sv
// fifo_tx_serializer: pops words from a show-ahead FIFO and sends each as a UART-style frame (start, DATA_W bits LSB first, STOP_BITS stop bits); define FIFO_TX_PARITY_EN to add an even-parity bit before the stop bits
module fifo_tx_serializer #(
    parameter int DATA_W       = 16,
    parameter int CLKS_PER_BIT = 4,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable_i,
    input  logic              fifo_empty_i,
    input  logic [DATA_W-1:0] fifo_data_i,
    output logic              fifo_pop_o,
    output logic              tx_o,
    output logic              busy_o,
    output logic [15:0]       frame_cnt_o
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_W);
`ifdef FIFO_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    logic par;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif
    state_t state;
    logic [CW-1:0] clk_cnt;
    logic [BW-1:0] bit_cnt;
    logic [DATA_W-1:0] sreg;
    logic bit_end, frame_end;
    assign bit_end = clk_cnt == CW'(CLKS_PER_BIT - 1);
    // bit_cnt doubles as the stop-bit counter while in STOP
    assign frame_end = state == STOP && bit_end && bit_cnt == BW'(STOP_BITS - 1);
    // reset gates the pop so the FIFO never advances while the serializer is held in reset
    assign fifo_pop_o = reset & enable_i & ~fifo_empty_i & (state == IDLE | frame_end);
    // frame sequencer: bit timing, shift register, registered line and busy outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            clk_cnt     <= '0;
            bit_cnt     <= '0;
            sreg        <= '0;
            tx_o        <= 1'b1;
            busy_o      <= 1'b0;
            frame_cnt_o <= '0;
`ifdef FIFO_TX_PARITY_EN
            par         <= 1'b0;
`endif
        end else begin
            clk_cnt <= (state == IDLE || bit_end) ? '0 : clk_cnt + 1'b1;
            if (frame_end)
                frame_cnt_o <= frame_cnt_o + 16'd1;
            if (fifo_pop_o) begin
                sreg    <= fifo_data_i;
                state   <= START;
                tx_o    <= 1'b0;
                busy_o  <= 1'b1;
                bit_cnt <= '0;
`ifdef FIFO_TX_PARITY_EN
                par     <= ^fifo_data_i;
`endif
            end else if (bit_end) begin
                case (state)
                    START: begin
                        state   <= DATA;
                        tx_o    <= sreg[0];
                        bit_cnt <= '0;
                    end
                    DATA: begin
                        if (bit_cnt == BW'(DATA_W - 1)) begin
`ifdef FIFO_TX_PARITY_EN
                            state <= PARITY;
                            tx_o  <= par;
`else
                            state <= STOP;
                            tx_o  <= 1'b1;
`endif
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            sreg    <= {1'b0, sreg[DATA_W-1:1]};
                            tx_o    <= sreg[1];
                        end
                    end
`ifdef FIFO_TX_PARITY_EN
                    PARITY: begin
                        state   <= STOP;
                        tx_o    <= 1'b1;
                        bit_cnt <= '0;
                    end
`endif
                    STOP: begin
                        if (frame_end) begin
                            state  <= IDLE;
                            busy_o <= 1'b0;
                            tx_o   <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_fifo_tx_serializer.sv
// tb_fifo_tx_serializer: self-checking bench with a frame-position reference model, vector table and directed corner sequences
module tb_fifo_tx_serializer;
    localparam int DW  = 16;
    localparam int CPB = 4;
    localparam int SB  = 1;
`ifdef FIFO_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int FL = (1 + DW + PB + SB) * CPB;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic enable_i = 1'b0;
    logic fifo_empty_i = 1'b1;
    logic [DW-1:0] fifo_data_i = '0;
    logic fifo_pop_o, tx_o, busy_o;
    logic [15:0] frame_cnt_o;

    fifo_tx_serializer #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .STOP_BITS(SB)) dut (
        .clk(clk), .reset(reset), .enable_i(enable_i), .fifo_empty_i(fifo_empty_i),
        .fifo_data_i(fifo_data_i), .fifo_pop_o(fifo_pop_o), .tx_o(tx_o),
        .busy_o(busy_o), .frame_cnt_o(frame_cnt_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [DW-1:0] q[$];
    int pos = -1;
    logic [DW-1:0] mword = '0;
    logic [15:0] mcnt = '0;
    logic s_pop, s_tx, s_busy;
    int nfr = 0;

    typedef struct {
        logic [DW-1:0] word;
        logic          par;
    } vec_t;
    vec_t vecs[6];

    task automatic chk(input string n, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", n, got, exp, $time);
        end
    endtask

    function automatic logic fbit(logic [DW-1:0] w, int b, logic p);
        if (b == 0) return 1'b0;
        if (b <= DW) return w[b-1];
        if (PB == 1 && b == DW + 1) return p;
        return 1'b1;
    endfunction

    task automatic drive();
        fifo_empty_i = q.size() == 0;
        fifo_data_i  = q.size() != 0 ? q[0] : '0;
    endtask

    task automatic tick();
        logic ep;
        drive();
        @(negedge clk);
        s_pop = fifo_pop_o;
        s_tx = tx_o;
        s_busy = busy_o;
        ep = reset && enable_i && q.size() != 0 && (pos < 0 || pos == FL - 1);
        chk("pop", s_pop, ep);
        chk("tx", s_tx, pos < 0 ? 1'b1 : fbit(mword, pos / CPB, ^mword));
        chk("busy", s_busy, pos >= 0);
        chk("frame_cnt", frame_cnt_o, mcnt);
        if (!reset) begin
            pos = -1;
            mcnt = '0;
        end else begin
            if (pos == FL - 1) mcnt++;
            if (ep) begin
                mword = q[0];
                pos = 0;
            end else if (pos == FL - 1) pos = -1;
            else if (pos >= 0) pos++;
        end
        @(posedge clk);
        #1;
        if (s_pop && q.size() != 0) void'(q.pop_front());
        drive();
    endtask

    task automatic wait_pop();
        int k;
        k = 0;
        s_pop = 1'b0;
        while (!s_pop && k < 4 * FL) begin
            tick();
            k++;
        end
        if (!s_pop) chk("pop_timeout", 0, 1);
    endtask

    initial begin
        vecs = '{'{16'hA5C3, 1'b0}, '{16'h0001, 1'b1}, '{16'hFFFF, 1'b0},
                 '{16'h0000, 1'b0}, '{16'h8000, 1'b1}, '{16'h1234, 1'b1}};
        #1 reset = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        reset = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        chk("idle_cnt", frame_cnt_o, 0);

        enable_i = 1'b1;
        for (int v = 0; v < 6; v++) begin
            logic [FL-1:0] got, expv;
            int bz;
            got = '0;
            expv = '0;
            bz = 0;
            q.push_back(vecs[v].word);
            wait_pop();
            for (int i = 0; i < FL; i++) begin
                tick();
                got[i] = s_tx;
                bz += int'(s_busy);
                expv[i] = fbit(vecs[v].word, i / CPB, vecs[v].par);
            end
            nfr++;
            chk("frame_bits", got, expv);
            chk("busy_len", bz, FL);
            tick();
            chk("idle_after", s_busy, 0);
            chk("vec_cnt", frame_cnt_o, nfr);
        end

        begin
            int pops[$];
            int bz;
            bz = 0;
            enable_i = 1'b0;
            for (int i = 0; i < 8; i++) q.push_back(16'h1111 * (i + 1));
            tick();
            enable_i = 1'b1;
            for (int t = 0; t < 8 * FL + 20; t++) begin
                tick();
                if (s_pop) pops.push_back(t);
                bz += int'(s_busy);
            end
            nfr += 8;
            chk("drain_pops", pops.size(), 8);
            for (int i = 1; i < pops.size(); i++) chk("drain_gap", pops[i] - pops[i-1], FL);
            chk("drain_busy", bz, 8 * FL);
            chk("drain_cnt", frame_cnt_o, nfr);
            chk("drain_empty", q.size(), 0);
        end

        begin
            int np;
            np = 0;
            q.push_back(16'hBEEF);
            q.push_back(16'h0F0F);
            wait_pop();
            for (int i = 0; i < 30; i++) tick();
            enable_i = 1'b0;
            for (int i = 0; i < FL + 10; i++) begin
                tick();
                np += int'(s_pop);
            end
            nfr++;
            chk("gate_nopop", np, 0);
            chk("gate_idle", s_busy, 0);
            chk("gate_cnt", frame_cnt_o, nfr);
            enable_i = 1'b1;
            tick();
            chk("gate_pop", s_pop, 1);
            for (int i = 0; i < FL + 1; i++) tick();
            nfr++;
        end

        q.push_back(16'hC0DE);
        q.push_back(16'h5A5A);
        wait_pop();
        for (int i = 0; i < 4 + 4 * 5 + 2; i++) tick();
        chk("pre_rst_busy", busy_o, 1);
        reset = 1'b0;
        #1;
        chk("rst_tx", tx_o, 1);
        chk("rst_busy", busy_o, 0);
        chk("rst_pop", fifo_pop_o, 0);
        chk("rst_cnt", frame_cnt_o, 0);
        pos = -1;
        mcnt = '0;
        tick();
        tick();
        reset = 1'b1;
        wait_pop();
        chk("rst_next_word", mword, 16'h5A5A);
        for (int i = 0; i < FL + 1; i++) tick();
        chk("rst_frame_cnt", frame_cnt_o, 1);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0 && q.size() < 16) q.push_back(DW'($urandom));
            if ($urandom_range(0, 59) == 0) enable_i = $urandom_range(0, 3) != 0;
            tick();
        end
        enable_i = 1'b1;
        for (int i = 0; i < 18 * FL && (q.size() != 0 || s_busy); i++) tick();
        chk("final_empty", q.size(), 0);
        chk("final_idle", s_busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fifo_tx_serializer.md
Name: fifo_tx_serializer

Overview:
- Downstream consumer of the 16-bit synchronous FIFO.
- Pops one word whenever the FIFO is non-empty and the serializer is free, then shifts it out on a single-wire UART-style line.
- Frame format: start bit (0), DATA_W data bits LSB first, optional parity bit, STOP_BITS stop bits (1).
- Sits between the FIFO's pop side and the chip-level serial pin.

Parameters:
- DATA_W, 16, word width; must equal the upstream FIFO DATA_W.
- CLKS_PER_BIT, 4, clock cycles per serial bit; must be >= 2.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- enable_i  input  1  allows new words to be popped; does not abort a frame in progress.
- fifo_empty_i  input  1  FIFO empty_o.
- fifo_data_i  input  DATA_W  FIFO pop_data_o; show-ahead, head word valid whenever fifo_empty_i=0.
- fifo_pop_o  output  1  FIFO pop_i.
- tx_o  output  1  serial line; idles high.
- busy_o  output  1  high while a frame is being transmitted.
- frame_cnt_o  output  16  count of completed frames; wraps 0xFFFF->0.

Behaviour:
- Reset values (asserted asynchronously): tx_o=1, busy_o=0, frame_cnt_o=0, state=IDLE, all counters 0, shift register 0. fifo_pop_o=0 while reset=0.
- States: IDLE, START, DATA, PARITY (only with the optional feature), STOP.
- fifo_pop_o is combinational, =1 when enable_i & ~fifo_empty_i & (state==IDLE, or the last cycle of the last stop bit). Never asserted while fifo_empty_i=1.
- On a clock edge with fifo_pop_o=1:
  - shift register <= fifo_data_i.
  - state <= START, clk_cnt <= 0.
- Bit timing:
  - Each state holds for CLKS_PER_BIT cycles, tracked by clk_cnt 0..CLKS_PER_BIT-1.
  - DATA lasts DATA_W bit periods; bit_cnt runs 0..DATA_W-1; shift right after each bit.
- tx_o is registered and matches state: START=0, DATA=sreg[0], PARITY=parity bit, STOP=1, IDLE=1.
- Latency: tx_o falls on the edge after the popping edge, so it first reads 0 one cycle after fifo_pop_o=1.
- Frame length: (1+DATA_W+P+STOP_BITS)*CLKS_PER_BIT cycles, where P=1 with parity, else 0. Defaults: 72 cycles.
- busy_o=1 in every non-IDLE state.
- End of frame (last cycle of last stop bit):
  - frame_cnt_o increments at that edge.
  - If a pop occurs in the same cycle, go directly to START. Back-to-back frames have no extra idle cycle.
  - Otherwise go to IDLE.
- Deasserting enable_i mid-frame lets the frame complete normally. No new pop occurs until enable_i=1.
- Reset mid-frame: line returns high immediately. The partially sent word is lost; the FIFO pointer has already advanced.
- Counter widths: clk_cnt is $clog2(CLKS_PER_BIT) bits and bit_cnt is $clog2(DATA_W) bits. Neither may overflow for legal parameters.

Optional Feature:
- Macro: FIFO_TX_PARITY_EN.
- Defined:
  - PARITY state is inserted between DATA and STOP.
  - tx_o = even parity (XOR of all DATA_W bits of the popped word), computed at pop time.
  - Frame is one bit period longer (76 cycles at defaults).
- Undefined: PARITY state and parity logic are absent; DATA goes straight to STOP.

Test Plan:
- Reset/idle: hold reset=0 for 3 cycles, release, fifo_empty_i=1 for 20 cycles -> tx_o=1, busy_o=0, fifo_pop_o never 1, frame_cnt_o=0.
- Single word: fifo_data_i=0xA5C3 with empty=0 for one pop ->
  - exactly one pop cycle.
  - tx_o: 0 for 4 cycles, then bits 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 at 4 cycles each, then 1 for 4 cycles.
  - busy_o high 72 cycles; frame_cnt_o=1.
- Full FIFO drain: 8 words pushed beforehand, enable_i=1 ->
  - 8 pops spaced exactly 72 cycles apart.
  - tx_o never idles high between frames.
  - frame_cnt_o=8; FIFO empty afterwards.
- Enable gating: drop enable_i at cycle 30 of a frame with FIFO non-empty -> frame completes at cycle 72, no further pop; raise enable_i -> pop on that same cycle.
- Reset mid-frame: assert reset during DATA bit 5 -> tx_o=1 and busy_o=0 immediately; after release the next FIFO word is popped and framed from START.
- Parity (FIFO_TX_PARITY_EN): word 0xA5C3 -> parity bit 0; word 0x0001 -> parity bit 1; frame length 76 cycles.
